// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment patterns and types for display encoder and decoder
package seg7_pkg;
  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;
  localparam int N_DIGITS = 4;
  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A = 7'b0111111;
  localparam seg_t SEG_B = 7'b1111111;
  localparam seg_t SEG_C = 7'b1110111;
  localparam seg_t SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: multiplexed seven-segment display pins
interface seg7_scan_decoder_if;
  logic [6:0] a_to_g;
  logic [3:0] an;
  logic dp;
  modport master (output a_to_g, an, dp);
  modport slave (input a_to_g, an, dp);
endinterface

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: maps an active-low segment pattern back to its nibble
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  seg_t    seg,
  output nibble_t nib,
  output logic    known
);
  // D..F are displayed as 8, so the all-on pattern decodes to 8
  always_comb begin
    nib = 4'h0;
    known = 1'b1;
    case (seg)
      SEG_0: nib = 4'h0;
      SEG_1: nib = 4'h1;
      SEG_2: nib = 4'h2;
      SEG_3: nib = 4'h3;
      SEG_4: nib = 4'h4;
      SEG_5: nib = 4'h5;
      SEG_6: nib = 4'h6;
      SEG_7: nib = 4'h7;
      SEG_8: nib = 4'h8;
      SEG_9: nib = 4'h9;
      SEG_A: nib = 4'hA;
      SEG_B: nib = 4'hB;
      SEG_C: nib = 4'hC;
      default: known = 1'b0;
    endcase
  end
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples scanned display pins and reassembles the shown 16-bit value
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 2**21
) (
  input  logic                 clk,
  input  logic                 rst_i,
  seg7_scan_decoder_if.slave   pins,
  output logic [15:0]          x_o,
  output logic                 valid_o,
  output logic                 frame_err_o,
  output logic                 an_err_o,
  output logic                 stale_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [3:0] an_r, an_p, seen, seen_n, cap_mask;
  seg_t seg_r, seg_p;
  logic dp_unused_r;
  logic [7:0] cnt;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [15:0] slots, slots_n;
  logic err, err_n, chg, settled, done, tout, known;
  nibble_t nib;
  seg7_pattern_decode u_dec (.seg(seg_r), .nib(nib), .known(known));
  // a change seen this cycle means the counter is stale for the new pins
  always_comb begin
    chg = (an_r != an_p) || (seg_r != seg_p);
    settled = !chg && cnt == 8'(SETTLE_CYCLES - 1);
    cap_mask = (settled && an_r != 4'hF && $onehot(~an_r)) ? ~an_r : 4'h0;
    slots_n = slots;
    for (int k = 0; k < N_DIGITS; k++)
      if (cap_mask[k]) slots_n[4*k +: 4] = nib;
    seen_n = seen | cap_mask;
    err_n = err | ((|cap_mask) && !known);
    done = seen_n == 4'hF;
    tcnt_n = tcnt + 1'b1;
    tout = tcnt_n == TW'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge clk) begin
    if (rst_i) begin
      an_r <= 4'hF;
      an_p <= 4'hF;
      seg_r <= 7'h7F;
      seg_p <= 7'h7F;
      dp_unused_r <= 1'b0;
      cnt <= 8'd0;
      slots <= 16'h0;
      seen <= 4'h0;
      err <= 1'b0;
      tcnt <= '0;
      x_o <= 16'h0;
      valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      an_err_o <= 1'b0;
      stale_o <= 1'b0;
    end else begin
      an_r <= pins.an;
      seg_r <= pins.a_to_g;
      dp_unused_r <= pins.dp;
      an_p <= an_r;
      seg_p <= seg_r;
      cnt <= chg ? 8'd0 : (cnt == 8'(SETTLE_CYCLES) ? cnt : cnt + 8'd1);
      slots <= slots_n;
      an_err_o <= settled && $countones(~an_r) > 1;
      valid_o <= done;
      frame_err_o <= done && err_n;
      if (done) begin
        x_o <= slots_n;
        seen <= 4'h0;
        err <= 1'b0;
        tcnt <= '0;
        stale_o <= 1'b0;
      end else if (tout) begin
        seen <= 4'h0;
        err <= 1'b0;
        tcnt <= '0;
        stale_o <= 1'b1;
      end else begin
        seen <= seen_n;
        err <= err_n;
        tcnt <= tcnt_n;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed scan-model bench for the display pin decoder
module tb_seg7_scan_decoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  seg7_scan_decoder_if pins();
  logic [15:0] x, tx;
  logic valid, ferr, anerr, stale, tvalid, tferr, tanerr, tstale;
  seg7_scan_decoder #(.SETTLE_CYCLES(4)) u_dut (
    .clk(clk), .rst_i(rst), .pins(pins), .x_o(x), .valid_o(valid),
    .frame_err_o(ferr), .an_err_o(anerr), .stale_o(stale));
  seg7_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64)) u_to (
    .clk(clk), .rst_i(rst), .pins(pins), .x_o(tx), .valid_o(tvalid),
    .frame_err_o(tferr), .an_err_o(tanerr), .stale_o(tstale));
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int passed = 0, total = 0;
  int vcnt, tvcnt, lat, vcyc, tvcyc;
  logic [15:0] lx;
  logic le;
  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0111111;
      4'hB: return 7'b1111111;
      4'hC: return 7'b1110111;
      default: return 7'b0000000;
    endcase
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic sample(input int k, input int c);
    if (valid) begin
      vcnt++;
      lx = x;
      le = ferr;
      vcyc = cyc;
      if (k == 3) lat = c;
    end
    if (tvalid) begin
      tvcnt++;
      tvcyc = cyc;
    end
  endtask
  // driver model: anode first, segment pattern one cycle later, then idle
  task automatic scan(input logic [15:0] v, input logic [3:0] mask, input int dwell, input int bad);
    vcnt = 0;
    tvcnt = 0;
    lat = -1;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        pins.an = ~(4'b0001 << k);
        tick;
        sample(k, 0);
        pins.a_to_g = (k == bad) ? 7'b1010101 : enc(v[4*k +: 4]);
        for (int c = 1; c < dwell; c++) begin
          tick;
          sample(k, c);
        end
      end
    end
    pins.an = 4'hF;
    pins.a_to_g = 7'h7F;
    for (int c = 0; c < 8; c++) begin
      tick;
      sample(4, c);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    total++; if (x !== 16'h0) $display("FAIL reset_x got %h want 0000", x); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else passed++;
    total++; if (ferr !== 1'b0) $display("FAIL reset_frame_err got %b want 0", ferr); else passed++;
    total++; if (anerr !== 1'b0) $display("FAIL reset_an_err got %b want 0", anerr); else passed++;
    total++; if (stale !== 1'b0) $display("FAIL reset_stale got %b want 0", stale); else passed++;
  endtask
  task automatic test_frame;
    scan(16'h1234, 4'hF, 16, -1);
    total++; if (vcnt !== 1) $display("FAIL f1234_pulses got %0d want 1", vcnt); else passed++;
    total++; if (lx !== 16'h1234) $display("FAIL f1234_x got %h want 1234", lx); else passed++;
    total++; if (le !== 1'b0) $display("FAIL f1234_err got %b want 0", le); else passed++;
    total++; if (lat !== 6) $display("FAIL f1234_latency got %0d want 6", lat); else passed++;
    scan(16'hCBA9, 4'hF, 16, -1);
    total++; if (vcnt !== 1) $display("FAIL fCBA9_pulses got %0d want 1", vcnt); else passed++;
    total++; if (lx !== 16'hCBA9) $display("FAIL fCBA9_x got %h want cba9", lx); else passed++;
    scan(16'hF000, 4'hF, 16, -1);
    total++; if (lx !== 16'h8000) $display("FAIL fF000_x got %h want 8000", lx); else passed++;
    total++; if (le !== 1'b0) $display("FAIL fF000_err got %b want 0", le); else passed++;
    total++; if (stale !== 1'b0) $display("FAIL long_stale got %b want 0", stale); else passed++;
  endtask
  task automatic test_bad_pattern;
    scan(16'h1234, 4'hF, 16, 2);
    total++; if (vcnt !== 1) $display("FAIL bad_pulses got %0d want 1", vcnt); else passed++;
    total++; if (lx !== 16'h1034) $display("FAIL bad_x got %h want 1034", lx); else passed++;
    total++; if (le !== 1'b1) $display("FAIL bad_err got %b want 1", le); else passed++;
    scan(16'h5678, 4'hF, 16, -1);
    total++; if (lx !== 16'h5678) $display("FAIL clean_x got %h want 5678", lx); else passed++;
    total++; if (le !== 1'b0) $display("FAIL clean_err got %b want 0", le); else passed++;
  endtask
  task automatic test_an_err;
    int p = 0, tp = 0;
    pins.an = 4'b1100;
    pins.a_to_g = enc(4'h1);
    for (int c = 0; c < 10; c++) begin
      tick;
      if (anerr) p++;
      if (tanerr) tp++;
    end
    pins.an = 4'hF;
    pins.a_to_g = 7'h7F;
    for (int c = 0; c < 4; c++) begin
      tick;
      if (anerr) p++;
      if (tanerr) tp++;
    end
    total++; if (p !== 1) $display("FAIL an_err_pulses got %0d want 1", p); else passed++;
    total++; if (tp !== 1) $display("FAIL an_err_pulses_to got %0d want 1", tp); else passed++;
    scan(16'h9876, 4'b1100, 16, -1);
    total++; if (vcnt !== 0) $display("FAIL an_err_seen got %0d pulses want 0", vcnt); else passed++;
    scan(16'h9876, 4'b0011, 16, -1);
    total++; if (vcnt !== 1) $display("FAIL split_pulses got %0d want 1", vcnt); else passed++;
    total++; if (lx !== 16'h9876) $display("FAIL split_x got %h want 9876", lx); else passed++;
  endtask
  task automatic test_short_dwell;
    scan(16'h4321, 4'hF, 4, -1);
    total++; if (vcnt !== 0) $display("FAIL short_pulses got %0d want 0", vcnt); else passed++;
    scan(16'h4321, 4'b0111, 16, -1);
    total++; if (vcnt !== 0) $display("FAIL short_seen got %0d pulses want 0", vcnt); else passed++;
    scan(16'h4321, 4'b1000, 16, -1);
    total++; if (vcnt !== 1) $display("FAIL short_done_pulses got %0d want 1", vcnt); else passed++;
    total++; if (lx !== 16'h4321) $display("FAIL short_done_x got %h want 4321", lx); else passed++;
  endtask
  task automatic test_repeat;
    scan(16'h00AB, 4'b0011, 16, -1);
    scan(16'h0007, 4'b0001, 16, -1);
    total++; if (vcnt !== 0) $display("FAIL repeat_pulses got %0d want 0", vcnt); else passed++;
    scan(16'h1200, 4'b1100, 16, -1);
    total++; if (vcnt !== 1) $display("FAIL repeat_done_pulses got %0d want 1", vcnt); else passed++;
    total++; if (lx !== 16'h12A7) $display("FAIL repeat_x got %h want 12a7", lx); else passed++;
  endtask
  task automatic test_reset_midframe;
    scan(16'h1111, 4'b0011, 16, -1);
    rst = 1'b1;
    repeat (2) tick;
    rst = 1'b0;
    total++; if (x !== 16'h0) $display("FAIL mid_reset_x got %h want 0000", x); else passed++;
    scan(16'h2222, 4'b1100, 16, -1);
    total++; if (vcnt !== 0) $display("FAIL mid_partial_pulses got %0d want 0", vcnt); else passed++;
    total++; if (x !== 16'h0) $display("FAIL mid_partial_x got %h want 0000", x); else passed++;
    scan(16'h3344, 4'b0011, 16, -1);
    total++; if (vcnt !== 1) $display("FAIL mid_done_pulses got %0d want 1", vcnt); else passed++;
    total++; if (lx !== 16'h2244) $display("FAIL mid_done_x got %h want 2244", lx); else passed++;
  endtask
  task automatic test_stale;
    int d = -1;
    rst = 1'b1;
    repeat (2) tick;
    rst = 1'b0;
    scan(16'h4321, 4'hF, 8, -1);
    total++; if (tvcnt !== 1) $display("FAIL to_pulses got %0d want 1", tvcnt); else passed++;
    total++; if (tx !== 16'h4321) $display("FAIL to_x got %h want 4321", tx); else passed++;
    total++; if (tferr !== 1'b0) $display("FAIL to_err got %b want 0", tferr); else passed++;
    total++; if (tstale !== 1'b0) $display("FAIL to_stale_early got %b want 0", tstale); else passed++;
    for (int c = 0; c < 200 && d < 0; c++) begin
      tick;
      if (tstale) d = cyc - tvcyc;
    end
    total++; if (d !== 63) $display("FAIL stale_delay got %0d want 63", d); else passed++;
    scan(16'h5555, 4'hF, 8, -1);
    total++; if (tvcnt !== 1) $display("FAIL to_pulses2 got %0d want 1", tvcnt); else passed++;
    total++; if (tstale !== 1'b0) $display("FAIL stale_clear got %b want 0", tstale); else passed++;
    total++; if (tx !== 16'h5555) $display("FAIL to_x2 got %h want 5555", tx); else passed++;
  endtask
  initial begin
    rst = 1'b0;
    pins.an = 4'hF;
    pins.a_to_g = 7'h7F;
    pins.dp = 1'b0;
    test_reset;
    test_frame;
    test_bad_pattern;
    test_an_err;
    test_short_dwell;
    test_repeat;
    test_reset_midframe;
    test_stale;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the 4-digit seven-segment scan controller.
- Monitors the multiplexed display pins (an, a_to_g, dp), captures the segment pattern shown on each digit, and decodes it back to a nibble.
- Reassembles the 16-bit displayed value and reports each complete frame with a one-cycle valid pulse.
- Used on-chip for display loopback self-test and as a bench checker for the display path.

Parameters:
- SETTLE_CYCLES, 4, cycles an and a_to_g must be unchanged before a digit is sampled (range 2..255).
- TIMEOUT_CYCLES, 2**21, cycles without a completed frame before stale_o asserts (at least 2 full scan periods).

Ports:
- clk  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- a_to_g  in  7  segment pins {g,f,e,d,c,b,a}, active-low.
- an  in  4  anode enables, active-low, one-hot-low when a digit is lit.
- dp  in  1  decimal point pin; registered but ignored.
- x_o  out  16  last completed frame; digit k occupies bits [4k+3:4k].
- valid_o  out  1  one-cycle pulse when x_o updates.
- frame_err_o  out  1  qualifies valid_o: frame contained an undecodable pattern.
- an_err_o  out  1  one-cycle pulse: more than one anode active.
- stale_o  out  1  level: no frame completed within TIMEOUT_CYCLES.

Behaviour:
- Reset (rst_i=1 at a clk edge): x_o=0, valid_o=0, frame_err_o=0, an_err_o=0, stale_o=0. Internal state also clears: seen mask, sticky error, settle counter, timeout counter, input registers (an_r=4'hF, a_to_g_r=7'h7F). Reset mid-frame discards partial digits.
- Input stage: an, a_to_g and dp are registered once (an_r, a_to_g_r). All logic uses the registered values.
- Settle counter:
  - Clears to 0 in any cycle where an_r or a_to_g_r differs from its previous value. Otherwise it increments, saturating at SETTLE_CYCLES.
  - Exists because the driver updates its digit register one cycle after its anode select changes.
- Anode classification on an_r:
  - 4'hF means idle: no capture.
  - Exactly one zero bit means active digit index idx.
  - Two or more zero bits: an_err_o pulses once when the settle counter reaches SETTLE_CYCLES-1. No capture.
- Capture:
  - Occurs in the cycle the settle counter equals SETTLE_CYCLES-1 with a valid idx. This gives exactly one capture per dwell.
  - Effect: slot[idx] <= decode(a_to_g_r) and seen[idx] <= 1.
  - Undecodable pattern: slot gets 4'h0 and the sticky frame error is set.
- Decode table (pattern -> nibble):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4.
  - 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9.
  - 0111111->A, 1111111->B, 1110111->C.
  - Any other pattern is undecodable.
  - Values D..F drive 0000000 and decode as 8; this is a known, accepted ambiguity.
- Frame completion:
  - When the seen mask (including a capture made in the same cycle) is 4'hF, the next cycle gives: x_o = assembled slots (including the newly captured nibble), valid_o=1, frame_err_o = sticky error.
  - In that same cycle, seen and sticky error clear.
  - Latency: valid_o rises SETTLE_CYCLES+2 cycles after the last pin change of the completing digit.
- Repeated digit: re-capturing an already-seen idx overwrites its slot and does not complete a frame.
- Timeout and stale:
  - The timeout counter clears on every valid_o and otherwise increments.
  - On reaching TIMEOUT_CYCLES-1: stale_o <= 1, seen cleared, sticky error cleared, counter restarts.
  - stale_o clears in the cycle valid_o asserts.
- frame_err_o is low whenever valid_o is low.

Decomposition:
- Package seg7_pkg holds:
  - localparams SEG_0..SEG_C (7-bit patterns above), SEG_BLANK, N_DIGITS=4.
  - typedef seg_t (logic [6:0]).
  - typedef nibble_t.
- The existing display controller is to be refactored to use the same package constants, so encoder and decoder cannot drift.
- Sub-module seg7_pattern_decode, combinational: seg_t in -> nibble_t plus a known flag. Shared by any later segment checker.

Test Plan:
- Behavioural scan model drives x=16'h1234 with 16-cycle dwell per digit and a 1-cycle digit lag -> after 4 dwells, valid_o pulses with x_o=16'h1234, frame_err_o=0. Pulse lands SETTLE_CYCLES+2 cycles after the digit-3 pin change.
- Scan x=16'hCBA9 -> x_o=16'hCBA9. Scan x=16'hF000 -> x_o=16'h8000, frame_err_o=0.
- Force a_to_g=7'b1010101 during the digit-2 dwell -> valid_o with x_o[11:8]=0 and frame_err_o=1. The next clean frame gives frame_err_o=0.
- Drive an=4'b1100 for 10 cycles -> exactly one an_err_o pulse, no change to seen. Dwell shorter than SETTLE_CYCLES -> no capture.
- Assert rst_i after 2 digits captured, then resume the scan -> x_o stays 0 until a full 4-digit frame. That frame uses only post-reset digits.
- Hold an=4'hF with TIMEOUT_CYCLES=64 -> stale_o rises at cycle 63 after the last valid_o. It falls with the next valid_o.
